// File: rtl/read_arbiter.sv
// Read arbiter for one image memory pool group: sticky-priority grant between conv, misc and save,
// a registered read issue to the group's block RAMs, and tagged return of the read data to the requester.
module read_arbiter #(
   parameter int ROW_PARA    = 4,
   parameter int ADDR_WIDTH  = 48,
   parameter int DATA_WIDTH  = 256,
   parameter int RAM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  conv_read_valid_i,
   input  logic [ROW_PARA-1:0]   conv_read_bank_en_i,
   input  logic [ADDR_WIDTH-1:0] conv_read_addr_i,
   output logic                  conv_read_ready_o,
   output logic [DATA_WIDTH-1:0] conv_read_data_o,
   output logic                  conv_read_data_valid_o,

   input  logic                  misc_read_valid_i,
   input  logic [ROW_PARA-1:0]   misc_read_bank_en_i,
   input  logic [ADDR_WIDTH-1:0] misc_read_addr_i,
   output logic                  misc_read_ready_o,
   output logic [DATA_WIDTH-1:0] misc_read_data_o,
   output logic                  misc_read_data_valid_o,

   input  logic                  save_read_valid_i,
   input  logic [ROW_PARA-1:0]   save_read_bank_en_i,
   input  logic [ADDR_WIDTH-1:0] save_read_addr_i,
   output logic                  save_read_ready_o,
   output logic [DATA_WIDTH-1:0] save_read_data_o,
   output logic                  save_read_data_valid_o,

   output logic                  ram_read_en_o,
   output logic [ROW_PARA-1:0]   ram_read_bank_en_o,
   output logic [ADDR_WIDTH-1:0] ram_read_addr_o,
   input  logic [DATA_WIDTH-1:0] ram_read_data_i
);

   typedef enum logic [2:0] {
      ST_NONE = 3'b000,
      ST_CONV = 3'b001,
      ST_MISC = 3'b010,
      ST_SAVE = 3'b100
   } read_state_t;

   read_state_t read_state_r;
   read_state_t read_state_next;

   logic [2:0]            req_valid;
   logic [2:0]            grant_next;
   logic [ROW_PARA-1:0]   grant_bank;
   logic [ADDR_WIDTH-1:0] grant_addr;

   logic                  ram_read_en_reg;
   logic [ROW_PARA-1:0]   ram_bank_en_reg;
   logic [ADDR_WIDTH-1:0] ram_addr_reg;

   // Stage 0 travels with the issue register; stage RAM_LATENCY lines up with valid RAM data.
   logic [2:0]            tag_pipe_reg [0:RAM_LATENCY];
   logic [2:0]            tag_out;

   logic [DATA_WIDTH-1:0] ret_data  [0:2];
   logic [2:0]            ret_valid;

   assign req_valid = {save_read_valid_i, misc_read_valid_i, conv_read_valid_i};

   always_comb begin
      read_state_next = ST_NONE;
      case (read_state_r)
         ST_CONV: begin
            if (req_valid[0])      read_state_next = ST_CONV;
            else if (req_valid[1]) read_state_next = ST_MISC;
            else if (req_valid[2]) read_state_next = ST_SAVE;
         end
         ST_MISC: begin
            if (req_valid[1])      read_state_next = ST_MISC;
            else if (req_valid[0]) read_state_next = ST_CONV;
            else if (req_valid[2]) read_state_next = ST_SAVE;
         end
         ST_SAVE: begin
            if (req_valid[2])      read_state_next = ST_SAVE;
            else if (req_valid[0]) read_state_next = ST_CONV;
            else if (req_valid[1]) read_state_next = ST_MISC;
         end
         default: begin
            // Idle and any corrupted encoding both resolve with plain conv > misc > save order.
            if (req_valid[0])      read_state_next = ST_CONV;
            else if (req_valid[1]) read_state_next = ST_MISC;
            else if (req_valid[2]) read_state_next = ST_SAVE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) read_state_r <= ST_NONE;
      else        read_state_r <= read_state_next;
   end

   // The next state only ever names a requester whose valid is high, so ready implies acceptance.
   assign grant_next        = read_state_next;
   assign conv_read_ready_o = grant_next[0];
   assign misc_read_ready_o = grant_next[1];
   assign save_read_ready_o = grant_next[2];

   always_comb begin
      grant_bank = '0;
      grant_addr = '0;
      if (grant_next[0]) begin
         grant_bank = conv_read_bank_en_i;
         grant_addr = conv_read_addr_i;
      end else if (grant_next[1]) begin
         grant_bank = misc_read_bank_en_i;
         grant_addr = misc_read_addr_i;
      end else if (grant_next[2]) begin
         grant_bank = save_read_bank_en_i;
         grant_addr = save_read_addr_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_read_en_reg <= 1'b0;
         ram_bank_en_reg <= '0;
         ram_addr_reg    <= '0;
      end else begin
         ram_read_en_reg <= |grant_next;
         ram_bank_en_reg <= grant_bank;
         if (|grant_next) ram_addr_reg <= grant_addr;
      end
   end

   assign ram_read_en_o      = ram_read_en_reg;
   assign ram_read_bank_en_o = ram_bank_en_reg;
   assign ram_read_addr_o    = ram_addr_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i <= RAM_LATENCY; i++) tag_pipe_reg[i] <= 3'b000;
      end else begin
         tag_pipe_reg[0] <= grant_next;
         for (int i = 1; i <= RAM_LATENCY; i++) tag_pipe_reg[i] <= tag_pipe_reg[i-1];
      end
   end

   assign tag_out = tag_pipe_reg[RAM_LATENCY];

   // One return register set per requester; only the tagged one captures RAM data.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ret
         logic [DATA_WIDTH-1:0] data_reg;
         logic                  valid_reg;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               data_reg  <= '0;
               valid_reg <= 1'b0;
            end else begin
               valid_reg <= tag_out[gi];
               if (tag_out[gi]) data_reg <= ram_read_data_i;
            end
         end

         assign ret_data[gi]  = data_reg;
         assign ret_valid[gi] = valid_reg;
      end
   endgenerate

   assign conv_read_data_o       = ret_data[0];
   assign misc_read_data_o       = ret_data[1];
   assign save_read_data_o       = ret_data[2];
   assign conv_read_data_valid_o = ret_valid[0];
   assign misc_read_data_valid_o = ret_valid[1];
   assign save_read_data_valid_o = ret_valid[2];

endmodule

// File: tb/tb_read_arbiter.sv
// Bench for read_arbiter: directed grant/issue checks plus a scoreboard of expected returns
// (data and arrival cycle) per requester; two extra instances cover RAM_LATENCY 1 and 4.
module tb_read_arbiter;

   localparam int AW = 48;
   localparam int DW = 256;
   localparam int RP = 4;

   typedef struct {
      int          cyc;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   ram_mode = 1'b0;
   bit   sweep_done [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic          conv_v, misc_v, save_v;
   logic [RP-1:0] conv_b, misc_b, save_b;
   logic [AW-1:0] conv_a, misc_a, save_a;
   logic          conv_rdy, misc_rdy, save_rdy;
   logic [DW-1:0] conv_d, misc_d, save_d;
   logic          conv_dv, misc_dv, save_dv;
   logic          ram_en;
   logic [RP-1:0] ram_bank;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;

   read_arbiter u_dut (
      .clk(clk), .rst_n(rst_n),
      .conv_read_valid_i(conv_v), .conv_read_bank_en_i(conv_b), .conv_read_addr_i(conv_a),
      .conv_read_ready_o(conv_rdy), .conv_read_data_o(conv_d), .conv_read_data_valid_o(conv_dv),
      .misc_read_valid_i(misc_v), .misc_read_bank_en_i(misc_b), .misc_read_addr_i(misc_a),
      .misc_read_ready_o(misc_rdy), .misc_read_data_o(misc_d), .misc_read_data_valid_o(misc_dv),
      .save_read_valid_i(save_v), .save_read_bank_en_i(save_b), .save_read_addr_i(save_a),
      .save_read_ready_o(save_rdy), .save_read_data_o(save_d), .save_read_data_valid_o(save_dv),
      .ram_read_en_o(ram_en), .ram_read_bank_en_o(ram_bank), .ram_read_addr_o(ram_addr),
      .ram_read_data_i(ram_data)
   );

   function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a, input bit m);
      return m ? {{(DW-AW){1'b0}}, a} : {32{8'hAA}};
   endfunction

   // RAM model: two-cycle read latency, garbage when not reading.
   logic [DW-1:0] ram_pipe [2];
   always @(posedge clk) begin
      ram_pipe[0] <= ram_en ? ram_word(ram_addr, ram_mode) : {8{32'hDEADBEEF}};
      ram_pipe[1] <= ram_pipe[0];
   end
   assign ram_data = ram_pipe[1];

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: push on acceptance, pop on data_valid.
   exp_t          sb_q [3][$];
   logic [2:0]    vld, rdy, dv;
   logic [AW-1:0] req_a [3];
   logic [DW-1:0] ret_d [3];
   assign vld = {save_v, misc_v, conv_v};
   assign rdy = {save_rdy, misc_rdy, conv_rdy};
   assign dv  = {save_dv, misc_dv, conv_dv};
   assign req_a[0] = conv_a;
   assign req_a[1] = misc_a;
   assign req_a[2] = save_a;
   assign ret_d[0] = conv_d;
   assign ret_d[1] = misc_d;
   assign ret_d[2] = save_d;

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) sb_q[i].delete();
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (dv[i]) begin
               if (sb_q[i].size() == 0) begin
                  check_eq($sformatf("unexpected_dv%0d", i), 1'b1, 1'b0);
               end else begin
                  exp_t e;
                  e = sb_q[i].pop_front();
                  check_eq($sformatf("ret_data%0d", i), ret_d[i], e.data);
                  check_eq($sformatf("ret_cycle%0d", i), cyc, e.cyc);
                  $display("ret req=%0d cyc=%0d data=%0h", i, cyc, ret_d[i]);
               end
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (vld[i] && rdy[i]) begin
               exp_t e;
               e.cyc  = cyc + 4;
               e.data = ram_word(req_a[i], ram_mode);
               sb_q[i].push_back(e);
               $display("acc req=%0d cyc=%0d addr=%0h", i, cyc, req_a[i]);
            end
         end
      end
   end

   // Latency sweep: single conv read on instances built with RAM_LATENCY 1 and 4.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
         localparam int LAT = (gi == 0) ? 1 : 4;
         logic          sv;
         logic [AW-1:0] sa;
         logic          s_rdy, m_rdy, v_rdy, s_dv, m_dv, v_dv, s_en;
         logic [DW-1:0] s_d, m_d, v_d, s_rd;
         logic [RP-1:0] s_bank;
         logic [AW-1:0] s_addr;
         logic [DW-1:0] mpipe [LAT];

         read_arbiter #(.RAM_LATENCY(LAT)) u_sweep (
            .clk(clk), .rst_n(rst_n),
            .conv_read_valid_i(sv), .conv_read_bank_en_i(4'b0001), .conv_read_addr_i(sa),
            .conv_read_ready_o(s_rdy), .conv_read_data_o(s_d), .conv_read_data_valid_o(s_dv),
            .misc_read_valid_i(1'b0), .misc_read_bank_en_i(4'b0000), .misc_read_addr_i(48'h0),
            .misc_read_ready_o(m_rdy), .misc_read_data_o(m_d), .misc_read_data_valid_o(m_dv),
            .save_read_valid_i(1'b0), .save_read_bank_en_i(4'b0000), .save_read_addr_i(48'h0),
            .save_read_ready_o(v_rdy), .save_read_data_o(v_d), .save_read_data_valid_o(v_dv),
            .ram_read_en_o(s_en), .ram_read_bank_en_o(s_bank), .ram_read_addr_o(s_addr),
            .ram_read_data_i(s_rd)
         );

         always @(posedge clk) begin
            mpipe[0] <= s_en ? {{(DW-AW){1'b0}}, s_addr} : '1;
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
         end
         assign s_rd = mpipe[LAT-1];

         initial begin
            int  start;
            bit  found;
            sv = 1'b0;
            sa = 48'h8000 + gi;
            found = 1'b0;
            wait (rst_n === 1'b1);
            @(posedge clk); #1;
            sv = 1'b1;
            start = cyc;
            check_eq($sformatf("sweep%0d_ready", LAT), s_rdy, 1'b1);
            @(posedge clk); #1;
            sv = 1'b0;
            for (int k = 0; k < 12 && !found; k++) begin
               @(negedge clk);
               if (s_dv) begin
                  found = 1'b1;
                  check_eq($sformatf("sweep%0d_latency", LAT), cyc - start, LAT + 2);
                  check_eq($sformatf("sweep%0d_data", LAT), s_d, {{(DW-AW){1'b0}}, sa});
                  $display("sweep lat=%0d latency=%0d", LAT, cyc - start);
               end
            end
            if (!found) check_eq($sformatf("sweep%0d_timeout", LAT), 1'b0, 1'b1);
            sweep_done[gi] = 1'b1;
         end
      end
   endgenerate

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      conv_v = 1'b0; misc_v = 1'b0; save_v = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      conv_a = '0; misc_a = '0; save_a = '0;
      conv_b = '0; misc_b = '0; save_b = '0;
      repeat (3) step();
      check_eq("rst_ram_en", ram_en, 1'b0);
      check_eq("rst_ram_bank", ram_bank, 4'b0);
      check_eq("rst_ram_addr", ram_addr, 48'h0);
      check_eq("rst_data_valid", dv, 3'b000);
      check_eq("rst_conv_data", conv_d, '0);
      check_eq("rst_ready", rdy, 3'b000);
      rst_n = 1'b1;

      // Single conv read
      step();
      conv_v = 1'b1; conv_a = 48'h10; conv_b = 4'b0011;
      #1 check_eq("t1_ready", rdy, 3'b001);
      step();
      conv_v = 1'b0;
      check_eq("t1_ram_en", ram_en, 1'b1);
      check_eq("t1_ram_addr", ram_addr, 48'h10);
      check_eq("t1_ram_bank", ram_bank, 4'b0011);
      step();
      check_eq("t1_idle_en", ram_en, 1'b0);
      check_eq("t1_idle_bank", ram_bank, 4'b0);
      check_eq("t1_addr_hold", ram_addr, 48'h10);
      repeat (4) step();

      // misc streams five reads; conv joins at the third and waits for the grant
      for (int k = 0; k < 5; k++) begin
         step();
         misc_v = 1'b1; misc_a = 48'h100 + k; misc_b = 4'b0001;
         if (k >= 2) begin
            conv_v = 1'b1; conv_a = 48'h200; conv_b = 4'b0010;
         end
         #1 check_eq($sformatf("t2_grant%0d", k), rdy, 3'b010);
      end
      step();
      misc_v = 1'b0;
      #1 check_eq("t2_conv_after", rdy, 3'b001);
      step();
      idle();
      repeat (6) step();

      // All three from idle, each dropping after one grant
      step();
      conv_v = 1'b1; misc_v = 1'b1; save_v = 1'b1;
      conv_a = 48'h300; misc_a = 48'h301; save_a = 48'h302;
      #1 check_eq("t3_g0", rdy, 3'b001);
      step();
      conv_v = 1'b0;
      #1 check_eq("t3_g1", rdy, 3'b010);
      step();
      misc_v = 1'b0;
      #1 check_eq("t3_g2", rdy, 3'b100);
      step();
      save_v = 1'b0;
      #1 check_eq("t3_none", rdy, 3'b000);
      repeat (6) step();

      // Alternating save/conv with address-as-data returns
      ram_mode = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         if (k % 2 == 0) begin
            save_v = 1'b1; conv_v = 1'b0; save_a = 48'h400 + k;
         end else begin
            conv_v = 1'b1; save_v = 1'b0; conv_a = 48'h500 + k;
         end
         #1 check_eq($sformatf("t4_grant%0d", k), rdy, (k % 2 == 0) ? 3'b100 : 3'b001);
      end
      step();
      idle();
      repeat (6) step();

      // Reset while three conv reads are in flight
      for (int k = 0; k < 3; k++) begin
         step();
         conv_v = 1'b1; conv_a = 48'h600 + k;
         #1 check_eq($sformatf("t5_ready%0d", k), conv_rdy, 1'b1);
      end
      step();
      conv_v = 1'b0;
      rst_n = 1'b0;
      step();
      check_eq("t5_ram_en", ram_en, 1'b0);
      check_eq("t5_ram_bank", ram_bank, 4'b0);
      check_eq("t5_ram_addr", ram_addr, 48'h0);
      check_eq("t5_state", u_dut.read_state_r, 3'b000);
      check_eq("t5_conv_data", conv_d, '0);
      rst_n = 1'b1;
      repeat (6) step();
      save_v = 1'b1; save_a = 48'h700;
      #1 check_eq("t5_save_ready", rdy, 3'b100);
      step();
      idle();
      repeat (6) step();

      for (int i = 0; i < 3; i++) check_eq($sformatf("sb_empty%0d", i), sb_q[i].size(), 0);
      check_eq("sweep_done", {sweep_done[1], sweep_done[0]}, 2'b11);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/read_arbiter.md
Name: read_arbiter

Overview:
- Read-side counterpart of the write arbiter for one image memory pool group.
- Accepts read requests from conv, misc and save, grants one per cycle with sticky priority, and issues a registered read to the group's block RAMs.
- Tracks the grant through the fixed RAM read latency and returns the read data, with a valid pulse, to the requester that issued it.

Parameters:
- ROW_PARA, 4: number of banks per group; width of the bank enable.
- ADDR_WIDTH, 48: read address width.
- DATA_WIDTH, 256: read data width.
- RAM_LATENCY, 2: cycles from ram_read_en_o to ram_read_data_i valid; legal range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- conv_read_valid_i  in  1  conv request
- conv_read_bank_en_i  in  ROW_PARA  conv bank enable
- conv_read_addr_i  in  ADDR_WIDTH  conv address
- conv_read_ready_o  out  1  conv granted this cycle
- conv_read_data_o  out  DATA_WIDTH  conv return data
- conv_read_data_valid_o  out  1  conv return strobe
- misc_read_* / misc_read_data_*: identical set of ports for misc.
- save_read_* / save_read_data_*: identical set of ports for save.
- ram_read_en_o  out  1  RAM read strobe
- ram_read_bank_en_o  out  ROW_PARA  RAM bank enable
- ram_read_addr_o  out  ADDR_WIDTH  RAM address
- ram_read_data_i  in  DATA_WIDTH  RAM data, valid RAM_LATENCY cycles after ram_read_en_o

Behaviour:
- Grant state is one-hot: NONE=000, CONV=001, MISC=010, SAVE=100. It is registered as read_state_r; the next state is combinational.
- Priority rules:
  - The current owner keeps the grant while its valid is high.
  - Otherwise the grant falls to the remaining requesters in the order conv > misc > save.
  - From NONE, the order is conv > misc > save.
  - An illegal state decodes to NONE.
- Ready outputs are the bits of the combinational next state. A request is accepted when valid & ready are both high in the same cycle.
- Exactly one ready output is high when any valid is high. All ready outputs are low when no valid is high.
- Ready never depends on return-path occupancy. The RAM pipeline is fully pipelined, and one request is accepted per cycle.
- Issue stage: on acceptance in cycle T, in cycle T+1:
  - ram_read_en_o = 1;
  - ram_read_bank_en_o and ram_read_addr_o = the granted requester's values (registered).
- With no acceptance, in the next cycle ram_read_en_o = 0 and ram_read_bank_en_o = 0. The address holds its last value.
- Tag pipeline:
  - The 3-bit one-hot grant is shifted alongside the request through RAM_LATENCY stages after the issue register.
  - When the tag emerges in cycle T+1+RAM_LATENCY, ram_read_data_i is captured into the tagged requester's data register.
  - That requester's data_valid is set in cycle T+2+RAM_LATENCY.
  - Total request-to-data latency is RAM_LATENCY+2 cycles (4 at default).
- Return outputs:
  - data_valid outputs are single-cycle strobes.
  - Each *_read_data_o holds its last captured value until the next return to that requester.
  - The other requesters' data registers are untouched.
  - Requesters must accept return data unconditionally; there is no return backpressure.
- Ordering: returns reach each requester in its issue order, and interleaved requesters each see only their own data.
- Reset (rst_n=0 at a clock edge):
  - read_state_r = NONE.
  - All tag stages are cleared.
  - ram_read_en_o = 0, bank_en = 0, addr = 0.
  - All data_valid = 0, all data outputs = 0.
  - Reset mid-operation drops all in-flight reads: no data_valid fires for a request accepted before reset. RAM data arriving after reset is ignored.
  - Ready outputs are combinational, so they may assert during reset. Requests accepted while rst_n=0 are discarded.
- Simultaneous events:
  - All three valids high from NONE: conv is granted.
  - Owner drop and new request in the same cycle: the next state is resolved in the same cycle with no idle bubble.

Test Plan:
- Reset, then conv_valid=1, addr=0x10, bank_en=4'b0011 for 1 cycle -> conv_ready=1 in the same cycle. Next cycle: ram_read_en_o=1, addr=0x10, bank_en=0011. RAM model returns 0xAA..AA; conv_read_data_valid_o=1 with that data exactly 4 cycles after acceptance. misc/save valid stay 0.
- misc streams 5 back-to-back requests; conv asserts valid at request 3 -> misc keeps the grant for all 5 and conv is granted on the 6th cycle. misc receives 5 returns in order, and conv's data arrives one cycle after misc's last.
- All three valids asserted from idle -> grant order conv, misc, save when each holds valid for exactly 1 cycle. The returns go to the matching ports in cycles T+4, T+5, T+6.
- Alternating save/conv requests each cycle, with the RAM returning the address as data -> each port sees only its own addresses. No cross-delivery, and no data_valid on misc.
- Accept 3 conv reads, then pull rst_n=0 for 1 cycle while they are in flight -> no conv_read_data_valid_o afterward, all ram outputs 0, and state NONE. A new save request after reset returns normally at +4.
- Parameter sweep RAM_LATENCY=1 and 4 -> request-to-data latency of 3 and 6 cycles respectively for a single request.
